// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, window/kernel types and arithmetic widths for the convolution pipeline.
package conv_pkg;
    localparam int C_SIGNAL_WIDTH     = 12;
    localparam int C_KERNEL_DIMENSION = 3;
    localparam int C_PRODUCT_WIDTH    = 2 * C_SIGNAL_WIDTH + 1;
    localparam int C_SUM_GROWTH       = $clog2(C_KERNEL_DIMENSION) + 1;
    localparam int C_ROW_WIDTH        = C_PRODUCT_WIDTH + C_SUM_GROWTH;
    localparam int C_TOTAL_WIDTH      = C_ROW_WIDTH + C_SUM_GROWTH;

    typedef logic [C_SIGNAL_WIDTH-1:0] pixel_t;
    typedef logic [C_KERNEL_DIMENSION-1:0][C_KERNEL_DIMENSION-1:0][C_SIGNAL_WIDTH-1:0] window_t;
    // Elements are two's-complement coefficients; signedness is applied per element on use.
    typedef logic [C_KERNEL_DIMENSION-1:0][C_KERNEL_DIMENSION-1:0][C_SIGNAL_WIDTH-1:0] kernel_t;
    typedef logic signed [C_PRODUCT_WIDTH-1:0] product_t;
    typedef logic signed [C_ROW_WIDTH-1:0] row_sum_t;
    typedef logic signed [C_TOTAL_WIDTH-1:0] total_sum_t;

    function automatic product_t multiply(input pixel_t pixel, input logic [C_SIGNAL_WIDTH-1:0] coeff);
        return product_t'($signed({1'b0, pixel})) * product_t'($signed(coeff));
    endfunction
endpackage

// File: rtl/conv_clamp.sv
// conv_clamp: saturates a signed convolution sum to the unsigned pixel range.
module conv_clamp
    import conv_pkg::*;
(
    input  total_sum_t sum,
    output pixel_t     pixel
);
    assign pixel = sum[C_TOTAL_WIDTH-1] ? '0 :
                   (|sum[C_TOTAL_WIDTH-2:C_SIGNAL_WIDTH]) ? '1 : sum[C_SIGNAL_WIDTH-1:0];
endmodule

// File: rtl/convolution_pipeline.sv
// convolution_pipeline: 5-stage KxK multiply-accumulate with output clamp, stalled by en.
// Optional CONV_PIPELINE_VALID_EN adds in_valid/output_valid carried alongside the data.
module convolution_pipeline
    import conv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
`ifdef CONV_PIPELINE_VALID_EN
    input  logic    in_valid,
    output logic    output_valid,
`endif
    input  window_t window_input,
    input  kernel_t filter,
    output pixel_t  output_pixel
);
    window_t    s1_window;
    kernel_t    s1_filter;
    product_t   s2_product [C_KERNEL_DIMENSION][C_KERNEL_DIMENSION];
    row_sum_t   s3_row [C_KERNEL_DIMENSION];
    total_sum_t s4_total;
    row_sum_t   row_acc [C_KERNEL_DIMENSION];
    total_sum_t total_acc;
    pixel_t     clamped;

    always_comb begin
        for (int r = 0; r < C_KERNEL_DIMENSION; r++) begin
            row_acc[r] = '0;
            for (int c = 0; c < C_KERNEL_DIMENSION; c++)
                row_acc[r] = row_acc[r] + row_sum_t'(s2_product[r][c]);
        end
    end

    always_comb begin
        total_acc = '0;
        for (int r = 0; r < C_KERNEL_DIMENSION; r++)
            total_acc = total_acc + total_sum_t'(s3_row[r]);
    end

    conv_clamp u_clamp (
        .sum   (s4_total),
        .pixel (clamped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_window    <= '0;
            s1_filter    <= '0;
            for (int r = 0; r < C_KERNEL_DIMENSION; r++) begin
                for (int c = 0; c < C_KERNEL_DIMENSION; c++)
                    s2_product[r][c] <= '0;
                s3_row[r] <= '0;
            end
            s4_total     <= '0;
            output_pixel <= '0;
        end else if (en) begin
            s1_window    <= window_input;
            s1_filter    <= filter;
            for (int r = 0; r < C_KERNEL_DIMENSION; r++) begin
                for (int c = 0; c < C_KERNEL_DIMENSION; c++)
                    s2_product[r][c] <= multiply(s1_window[r][c], s1_filter[r][c]);
                s3_row[r] <= row_acc[r];
            end
            s4_total     <= total_acc;
            output_pixel <= clamped;
        end
    end

`ifdef CONV_PIPELINE_VALID_EN
    logic [4:0] valid_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_pipe <= '0;
        else if (en)
            valid_pipe <= {valid_pipe[3:0], in_valid};
    end

    assign output_valid = valid_pipe[4];
`endif
endmodule

// File: tb/tb_convolution_pipeline.sv
// tb_convolution_pipeline: directed checks of latency, clamping, stall and async reset.
module tb_convolution_pipeline;
    import conv_pkg::*;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    en = 1'b0;
    window_t win = '0;
    kernel_t filt = '0;
    pixel_t  out_pix;
    int      checks = 0;
    int      errors = 0;

    convolution_pipeline dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .window_input (win),
        .filter       (filt),
        .output_pixel (out_pix)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic window_t flat(input int p);
        window_t w;
        for (int r = 0; r < C_KERNEL_DIMENSION; r++)
            for (int c = 0; c < C_KERNEL_DIMENSION; c++)
                w[r][c] = 12'(p);
        return w;
    endfunction

    function automatic kernel_t kern(input int centre, input int diag, input int other);
        kernel_t k;
        for (int r = 0; r < C_KERNEL_DIMENSION; r++)
            for (int c = 0; c < C_KERNEL_DIMENSION; c++)
                k[r][c] = (r != c) ? 12'(other) : (r == C_KERNEL_DIMENSION / 2) ? 12'(centre) : 12'(diag);
        return k;
    endfunction

    function automatic int ref_pixel(input window_t w, input kernel_t f);
        int s = 0;
        for (int r = 0; r < C_KERNEL_DIMENSION; r++)
            for (int c = 0; c < C_KERNEL_DIMENSION; c++)
                s += int'(w[r][c]) * int'($signed(f[r][c]));
        return s < 0 ? 0 : (s > 4095 ? 4095 : s);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b1;
        win = flat(4095);
        filt = kern(1, 0, 0);
        tick;
        tick;
        checks++;
        if (out_pix !== 12'd0) begin
            errors++;
            $display("FAIL reset_hold: got %0d expected 0", out_pix);
        end
        win = '0;
        filt = '0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (out_pix !== 12'd0) begin
            errors++;
            $display("FAIL reset_release: got %0d expected 0", out_pix);
        end
    endtask

    task automatic test_directed_stream;
        int exp_out [4] = '{0, 12, 0, 4095};
        win = flat(12);
        filt = kern(1, 0, 0);
        tick;
        win = flat(10);
        filt = kern(-1, -1, 0);
        tick;
        win = flat(4095);
        filt = kern(1, 1, 0);
        tick;
        win = '0;
        filt = '0;
        for (int k = 0; k < 4; k++) begin
            tick;
            checks++;
            if (out_pix !== 12'(exp_out[k])) begin
                errors++;
                $display("FAIL stream_edge_N+%0d: got %0d expected %0d", k + 3, out_pix, exp_out[k]);
            end
        end
    endtask

    task automatic test_boundaries;
        int pix  [9] = '{2048, 4095, 455, 1, 4095, 4095, 100, 4095, 4091};
        int all  [9] = '{0, 0, 1, 0, 1, 1, 1, 0, 0};
        int kv   [9] = '{2, 1, 1, -1, -2048, 2047, 1, 2, -1};
        int expv [9] = '{4095, 4095, 4095, 0, 0, 4095, 900, 4095, 0};
        for (int i = 0; i < 9; i++) begin
            win = flat(pix[i]);
            filt = all[i] != 0 ? kern(kv[i], kv[i], kv[i]) : kern(kv[i], 0, 0);
            for (int k = 0; k < 5; k++) tick;
            checks++;
            if (out_pix !== 12'(expv[i])) begin
                errors++;
                $display("FAIL boundary_%0d: got %0d expected %0d", i, out_pix, expv[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int exp_pipe [5] = '{0, 0, 0, 0, 0};
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en = !(i == 6 || i == 7);
            for (int r = 0; r < C_KERNEL_DIMENSION; r++)
                for (int c = 0; c < C_KERNEL_DIMENSION; c++) begin
                    win[r][c] = 12'((i * 97 + r * 31 + c * 17) % 512);
                    filt[r][c] = 12'((i + r * 3 + c * 5) % 7 - 3);
                end
            tick;
            if (en) begin
                for (int s = 4; s > 0; s--) exp_pipe[s] = exp_pipe[s - 1];
                exp_pipe[0] = ref_pixel(win, filt);
            end
            checks++;
            if (out_pix !== 12'(exp_pipe[4])) begin
                errors++;
                $display("FAIL b2b_cycle_%0d: got %0d expected %0d", i, out_pix, exp_pipe[4]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset;
        win = flat(100);
        filt = kern(1, 0, 0);
        for (int i = 0; i < 6; i++) tick;
        checks++;
        if (out_pix !== 12'd100) begin
            errors++;
            $display("FAIL pre_reset_data: got %0d expected 100", out_pix);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_pix !== 12'd0) begin
            errors++;
            $display("FAIL async_reset_clear: got %0d expected 0", out_pix);
        end
        tick;
        win = flat(7);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            checks++;
            if (out_pix !== (k == 5 ? 12'd7 : 12'd0)) begin
                errors++;
                $display("FAIL post_reset_edge_%0d: got %0d expected %0d", k, out_pix, k == 5 ? 7 : 0);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed_stream;
        test_boundaries;
        test_back_to_back;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/convolution_pipeline.md
Name: convolution_pipeline

Overview:
Pipelined 2-D convolution kernel for the image-processing datapath. Each enabled cycle it accepts one KxK window of unsigned pixels and one KxK signed filter. It computes the sum of element-wise products and clamps the result to the unsigned pixel range. It sits after the line-buffer/window generator and feeds one output pixel per cycle to the downstream writer.

Parameters:
C_SIGNAL_WIDTH, 12, pixel width and filter-coefficient width in bits.
C_KERNEL_DIMENSION, 3, kernel/window side length K (window is KxK).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  pipeline advance enable; when 0 every stage holds.
window_input  input  KxK array of C_SIGNAL_WIDTH  unsigned pixels, indexed [row 0..K-1][col 0..K-1].
filter  input  KxK array of C_SIGNAL_WIDTH signed  two's-complement coefficients, same indexing as window_input.
output_pixel  output  C_SIGNAL_WIDTH  clamped convolution result (unsigned).

Behaviour:
- Reset: rst=1 asynchronously clears every pipeline register and output_pixel to 0. A mid-stream reset discards all in-flight data.
- Pipeline: five register stages, all gated by en:
  - S1 registers window_input and filter.
  - S2 forms K*K products.
  - S3 forms K row sums.
  - S4 forms the total sum.
  - S5 clamps and registers output_pixel.
- Latency: data sampled at rising edge N (en=1 throughout) appears on output_pixel immediately after edge N+4.
- Throughput: one window per cycle.
- Stall: en=0 freezes all stages including output_pixel. There is no bubble insertion; data resumes when en returns to 1.
- Products: the pixel is zero-extended to C_SIGNAL_WIDTH+1 bits (signed), then multiplied by the signed coefficient. Product width is 2*C_SIGNAL_WIDTH+1 bits, signed.
- Accumulation: row and total sums are signed, each widened by ceil(log2(K))+1 bits so that no intermediate sum overflows. With the defaults the total is at least 29 bits.
- Clamp:
  - sum < 0 → 0.
  - sum > 2^C_SIGNAL_WIDTH-1 → 2^C_SIGNAL_WIDTH-1.
  - otherwise the low C_SIGNAL_WIDTH bits of sum.
- No normalisation or shift is applied; kernel scaling is the caller's responsibility.
- Any X on the inputs is only required to propagate when en=1.

Optional Feature:
Macro CONV_PIPELINE_VALID_EN.
- Defined: adds input port in_valid (1 bit) and output port output_valid (1 bit). in_valid is carried through a 5-deep shift register gated by en, so output_valid is aligned with output_pixel. output_valid resets to 0.
- Undefined: these ports and registers do not exist, and the datapath behaves identically.

Decomposition:
- Shared package conv_pkg holds:
  - constants C_SIGNAL_WIDTH=12 and C_KERNEL_DIMENSION=3;
  - typedef window_t (KxK unsigned pixel array);
  - typedef kernel_t (KxK signed coefficient array);
  - product/sum width constants derived from the above.
- One natural sub-module: conv_clamp, the combinational signed-sum-to-unsigned-pixel saturator used by S5.

Test Plan:
- All pixels 12, identity filter (centre 1, others 0), en=1 → output_pixel=12 after edge N+4.
- Next cycle: all pixels 10, filter diagonal -1, others 0 → sum -30 → output_pixel=0 one cycle after the previous result.
- Next cycle: all pixels 4095, filter diagonal 1 → sum 12285 → output_pixel=4095 (saturated).
- Back-to-back mixed windows with a 2-cycle en=0 gap mid-stream → output sequence matches a reference model, held constant during the stall, with no lost or duplicated samples.
- Assert rst mid-stream with data in flight → output_pixel goes to 0 immediately (asynchronously). After release, only post-reset inputs appear, at the required latency.
- All pixels 4095, all filter coefficients -2048 → large negative sum with no overflow → output_pixel=0. All coefficients 2047 → output_pixel=4095.
